booth4_seq_mult: RTL and testbench
==================================

Name: booth4_seq_mult

Overview:
- Parametrised, iterative radix-4 (modified Booth) multiplier for the arithmetic datapath.
- It is the sequential successor to our fixed 4x4 combinational Booth multiplier with its final ripple adder.
- It retires one Booth digit per clock into a single accumulator, so one adder serves any operand width.
- Operands and result use valid/ready handshakes; the operation is unsigned by default, with an optional signed mode.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a_i/b_i are presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a_i  input  WIDTH  multiplicand.
- b_i  input  WIDTH  multiplier (Booth-recoded).
- signed_i  input  1  treat operands as two's complement; only used when SIGNED_MODE_EN is defined.
- out_valid  output  1  product_o is valid and held.
- out_ready  input  1  consumer accepts the product.
- product_o  output  2*WIDTH  a*b.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the cycle after; out_valid=0; product_o=0; state=IDLE; accumulator and digit counter cleared.
- Reset mid-operation (CALC or DONE): the operation is discarded and the block returns to IDLE; no out_valid is produced for it.
- State machine:
  - IDLE: in_ready=1. On in_valid at an edge, capture a_i, b_i (and signed_i) and go to CALC.
  - CALC: in_ready=0. Process digit k = 0..NDIG-1, one per edge, LSB digit first.
  - DONE: out_valid=1; product_o is stable until the out_ready edge, then go to IDLE.
- DONE is never exited without out_ready. There is no same-cycle accept in DONE; a new operand is taken at the earliest in the following IDLE cycle.
- Digit count (NDIG): unsigned NDIG = WIDTH/2 + 1; signed NDIG = WIDTH/2.
- Recoding: b is extended with b[-1]=0. Unsigned extends with 2 zero MSBs; signed extends with sign bits.
- Digit k is taken from the triplet (b[2k+1], b[2k], b[2k-1]) and maps to 0, +1, +1, +2, -2, -1, -1, 0 for triplets 000..111.
- Partial product for digit k = digit * a * 4^k. Signed mode sign-extends a; unsigned mode zero-extends a.
- Accumulator width is 2*WIDTH+3 bits, two's complement; the -1/-2 digits use inversion plus carry-in, with no separate subtractor.
- product_o = accumulator[2*WIDTH-1:0], which is exact for both modes.
- Latency: if operands are accepted at edge T, out_valid rises after edge T+NDIG. Throughput is one product per NDIG+2 cycles with out_ready held high.
- in_valid while busy is ignored; the source must hold it until in_ready.
- Operand registers are not updated outside IDLE.
- product_o retains its last value after the handshake until the next DONE; it is 0 only after reset.

Optional Feature:
- Macro SIGNED_MODE_EN.
- Defined: signed_i is sampled with the operands. signed_i=1 selects two's-complement recoding with NDIG = WIDTH/2 and sign-extended a; signed_i=0 is unsigned.
- Undefined: signed_i is ignored, operation is always unsigned, and NDIG = WIDTH/2 + 1.
- The port list is identical in both builds.

Test Plan:
- WIDTH=4, a=15, b=15, out_ready=1 -> product_o=0x00E1 (225); out_valid exactly 3 cycles after the accept edge, high for 1 cycle.
- WIDTH=4, a=10, b=7 (digits -1, +2, 0) -> 0x0046 (70); a=0, b=9 -> 0x0000; a=9, b=0 -> 0x0000.
- WIDTH=8, a=255, b=255 -> 0xFE01; a=128, b=3 -> 0x0180; out_valid 5 cycles after accept.
- Backpressure: WIDTH=8, a=200, b=100, out_ready=0 for 10 cycles -> out_valid and product_o=0x4E20 held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset: rst=1 in the second CALC cycle -> next cycle out_valid=0, product_o=0, in_ready=1; a subsequent 6*7 returns 0x002A.
- SIGNED_MODE_EN defined, WIDTH=4, signed_i=1: a=-8, b=7 -> 0xC8; a=-8, b=-8 -> 0x40, out_valid 2 cycles after accept. With signed_i=0: a=8, b=9 -> 0x48.

Source files
------------

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 (modified Booth) multiplier: one Booth digit per clock into a single accumulator.
// Define SIGNED_MODE_EN to honour signed_i; otherwise every operation is unsigned.
module booth4_seq_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic               signed_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int unsigned AW = 2 * WIDTH + 3;
   localparam int unsigned BW = WIDTH + 3;
   localparam int unsigned CW = $clog2(WIDTH / 2 + 2);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e               state_q, state_d;
   logic [AW-1:0]        mcand_q, mcand_d;
   logic [BW-1:0]        mult_q, mult_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sgn_q, sgn_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic                 sgn_in;
   logic                 ext_a, ext_b;
   logic                 dig_one, dig_two, dig_neg;
   logic [AW-1:0]        pp;
   logic [AW-1:0]        acc_sum;
   logic [CW-1:0]        last_idx;

`ifdef SIGNED_MODE_EN
   assign sgn_in = signed_i;
`else
   logic unused_signed;
   assign sgn_in        = 1'b0;
   assign unused_signed = signed_i;
`endif

   assign ext_a    = sgn_in & a_i[WIDTH-1];
   assign ext_b    = sgn_in & b_i[WIDTH-1];
   assign last_idx = sgn_q ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);

   // Current digit sits in mult_q[2:0]; bit 0 carries b[2k-1].
   always_comb begin
      dig_one = 1'b0;
      dig_two = 1'b0;
      dig_neg = 1'b0;
      unique case (mult_q[2:0])
         3'b001, 3'b010: dig_one = 1'b1;
         3'b011:         dig_two = 1'b1;
         3'b100: begin
            dig_two = 1'b1;
            dig_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            dig_one = 1'b1;
            dig_neg = 1'b1;
         end
         default: ;
      endcase
   end

   assign pp      = dig_two ? (mcand_q << 1) : (dig_one ? mcand_q : '0);
   // Negative digits subtract via one's complement plus carry-in.
   assign acc_sum = acc_q + (dig_neg ? ~pp : pp) + AW'(dig_neg);

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mult_d    = mult_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      prod_d    = prod_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = ~rst;
            if (in_valid) begin
               sgn_d   = sgn_in;
               mcand_d = {{(AW - WIDTH){ext_a}}, a_i};
               mult_d  = {ext_b, ext_b, b_i, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 2;
            mult_d  = {{2{mult_q[BW-1]}}, mult_q[BW-1:2]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == last_idx) begin
               prod_d  = acc_sum[2*WIDTH-1:0];
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mcand_q <= '0;
         mult_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         prod_q  <= prod_d;
      end
   end

   assign product_o = prod_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Bench for booth4_seq_mult: WIDTH=4 and WIDTH=8 instances against a latency/arithmetic model.
// Build with SIGNED_MODE_EN to exercise the signed vectors.
module tb_booth4_seq_mult;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv4 = 1'b0, iv8 = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic        s = 1'b0;
   logic        ordy = 1'b1;
   logic        rdy4, ov4, rdy8, ov8;
   logic [7:0]  p4;
   logic [15:0] p8;

   booth4_seq_mult #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a_i(a[3:0]), .b_i(b[3:0]),
      .signed_i(s), .out_valid(ov4), .out_ready(ordy), .product_o(p4)
   );

   booth4_seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a_i(a), .b_i(b),
      .signed_i(s), .out_valid(ov8), .out_ready(ordy), .product_o(p8)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   // Model: accept time, completion time, expected and held product per instance.
   bit          m_on = 1'b0;
   bit          m_acc [2];
   int          m_tacc [2];
   int          m_tdone [2];
   logic [15:0] m_exp [2];
   logic [15:0] m_held [2];

   int          lit_seq [2];
   int          lit_done [2];
   logic [15:0] lit_val [2];
   int          lit_lat [2];
   int          tmo_cnt = 0, tmo_seen = 0;
   bit          done_req = 1'b0, done_ack = 1'b0;

   logic        ov_a [2], rdy_a [2], iv_a [2];
   logic [15:0] p_a [2];
   assign ov_a[0] = ov4;
   assign ov_a[1] = ov8;
   assign rdy_a[0] = rdy4;
   assign rdy_a[1] = rdy8;
   assign iv_a[0] = iv4;
   assign iv_a[1] = iv8;
   assign p_a[0] = {8'h00, p4};
   assign p_a[1] = p8;

   function automatic bit eff_signed(input bit sv);
`ifdef SIGNED_MODE_EN
      return sv;
`else
      return sv & 1'b0;
`endif
   endfunction

   function automatic logic [15:0] ref_mult(input int w, input logic [7:0] av,
                                            input logic [7:0] bv, input bit sg);
      int ua, ub, r, half;
      half = 1 << (w - 1);
      ua = (w == 4) ? int'(av[3:0]) : int'(av);
      ub = (w == 4) ? int'(bv[3:0]) : int'(bv);
      if (sg) begin
         if (ua >= half) ua -= 2 * half;
         if (ub >= half) ub -= 2 * half;
      end
      r = ua * ub;
      return 16'(r & ((1 << (2 * w)) - 1));
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit e_ov;
      bit sg;
      int w;
      for (int d = 0; d < 2; d++) begin
         w    = (d == 0) ? 4 : 8;
         e_ov = m_acc[d] && (cyc >= m_tdone[d]);
         if (m_on) begin
            chk($sformatf("out_valid w%0d", w), 16'(ov_a[d]), 16'(e_ov));
            chk($sformatf("in_ready w%0d", w), 16'(rdy_a[d]), 16'(!m_acc[d] && !rst));
            chk($sformatf("product w%0d", w), p_a[d], e_ov ? m_exp[d] : m_held[d]);
            if (ov_a[d] === 1'b1 && lit_seq[d] != lit_done[d]) begin
               chk($sformatf("literal product w%0d", w), p_a[d], lit_val[d]);
               chk($sformatf("latency w%0d", w), 16'(cyc - m_tacc[d]), 16'(lit_lat[d]));
               lit_done[d] = lit_seq[d];
            end
         end
         if (rst) begin
            m_acc[d]  = 1'b0;
            m_held[d] = '0;
         end else if (!m_acc[d] && iv_a[d]) begin
            sg         = eff_signed(s);
            m_acc[d]   = 1'b1;
            m_tacc[d]  = cyc + 1;
            m_tdone[d] = cyc + 1 + (sg ? w / 2 : w / 2 + 1);
            m_exp[d]   = ref_mult(w, a, b, sg);
         end else if (e_ov && ordy) begin
            m_acc[d]  = 1'b0;
            m_held[d] = m_exp[d];
         end
      end
      if (rst) m_on = 1'b1;
      if (tmo_cnt != tmo_seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL handshake timeout: got %0d expired waits required 0", tmo_cnt - tmo_seen);
         tmo_seen = tmo_cnt;
      end
      if (done_req && !done_ack) begin
         chk("pending literal w4", 16'(lit_done[0]), 16'(lit_seq[0]));
         chk("pending literal w8", 16'(lit_done[1]), 16'(lit_seq[1]));
         done_ack = 1'b1;
      end
   end

   // Presents one operand pair and returns once out_valid is seen (caller at posedge+1).
   task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic [15:0] lit, input int lat);
      int n;
      a = av;
      b = bv;
      s = sv;
      lit_val[d] = lit;
      lit_lat[d] = lat;
      lit_seq[d] = lit_seq[d] + 1;
      if (d == 0) iv4 = 1'b1;
      else iv8 = 1'b1;
      n = 0;
      while (rdy_a[d] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) tmo_cnt++;
      @(posedge clk); #1;
      iv4 = 1'b0;
      iv8 = 1'b0;
      n = 0;
      while (ov_a[d] !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) tmo_cnt++;
   endtask

   task automatic op(input int d, input logic [7:0] av, input logic [7:0] bv,
                     input logic sv, input logic [15:0] lit, input int lat);
      run_op(d, av, bv, sv, lit, lat);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         lit_seq[d]  = 0;
         lit_done[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      op(0, 8'd15, 8'd15, 1'b0, 16'h00E1, 3);
      op(0, 8'd10, 8'd7,  1'b0, 16'h0046, 3);
      op(0, 8'd0,  8'd9,  1'b0, 16'h0000, 3);
      op(0, 8'd9,  8'd0,  1'b0, 16'h0000, 3);
`ifdef SIGNED_MODE_EN
      op(0, 8'h08, 8'h07, 1'b1, 16'h00C8, 2);
      op(0, 8'h08, 8'h08, 1'b1, 16'h0040, 2);
      op(0, 8'h08, 8'h09, 1'b0, 16'h0048, 3);
      op(1, 8'hF6, 8'h03, 1'b1, 16'hFFE2, 4);
`else
      op(0, 8'h08, 8'h09, 1'b1, 16'h0048, 3);
      op(1, 8'hF6, 8'h03, 1'b1, 16'h02E2, 5);
`endif
      op(1, 8'd255, 8'd255, 1'b0, 16'hFE01, 5);
      op(1, 8'd128, 8'd3,   1'b0, 16'h0180, 5);

      // Backpressure: product must hold for 10 cycles with out_ready low.
      ordy = 1'b0;
      run_op(1, 8'd200, 8'd100, 1'b0, 16'h4E20, 5);
      repeat (10) begin
         @(posedge clk); #1;
      end
      ordy = 1'b1;
      @(posedge clk); #1;

      // Reset during the second CALC cycle discards the operation.
      a   = 8'd50;
      b   = 8'd60;
      iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      op(1, 8'd6, 8'd7, 1'b0, 16'h002A, 5);
      repeat (3) begin
         @(posedge clk); #1;
      end

      done_req = 1'b1;
      n = 0;
      while (!done_ack && n < 10) begin
         @(negedge clk);
         n++;
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
